// File: rtl/sevenseg_mux_decoder_if.sv
// ---------------------------------------------------------------------------
// sevenseg_mux_decoder_if
//   Bundles the multiplexed seven-segment display bus seen by the decoder
//   together with the decoded pair and status flags it publishes.
//
//   Signals:
//     seg_in      [7:0]  display bus, bit7 = select (1 tens, 0 ones),
//                        bits 6:0 = segments g..a, active-high
//     tens_out    [3:0]  last published tens code
//     ones_out    [3:0]  last published ones code
//     valid              published pair is current
//     update             one-cycle strobe on publish
//     invalid_err        one-cycle strobe with update when a code is 4'hE
//     stalled            select has not toggled for the timeout period
//
//   Modports:
//     master  drives the display bus and observes the decoded results
//     slave   the decoder: samples the bus and drives the results
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface sevenseg_mux_decoder_if;
  logic [7:0] seg_in;
  logic [3:0] tens_out;
  logic [3:0] ones_out;
  logic       valid;
  logic       update;
  logic       invalid_err;
  logic       stalled;

  modport master (
    output seg_in,
    input  tens_out,
    input  ones_out,
    input  valid,
    input  update,
    input  invalid_err,
    input  stalled
  );

  modport slave (
    input  seg_in,
    output tens_out,
    output ones_out,
    output valid,
    output update,
    output invalid_err,
    output stalled
  );
endinterface

// File: rtl/sevenseg_mux_decoder.sv
// ---------------------------------------------------------------------------
// sevenseg_mux_decoder
//   Receive side of the dual seven-segment display driver. The multiplexed
//   bus is synchronised, each select phase is allowed to settle, and the
//   settled segment pattern is decoded back into a 4-bit code. A tens
//   capture followed by a ones capture publishes a coherent pair with a
//   one-cycle update strobe. A bus whose select stops toggling is reported
//   as stalled and the published pair is marked no longer current.
//
//   Parameters:
//     STABLE_CYCLES   identical synchronised samples needed before a digit
//                     is captured within one select phase (1..15)
//     TIMEOUT_CYCLES  cycles without a select toggle before the bus is
//                     declared stalled (4..1023)
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous, active-low reset
//     bus    slave side of sevenseg_mux_decoder_if (display bus in,
//            decoded pair and status flags out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sevenseg_mux_decoder #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sevenseg_mux_decoder_if.slave       bus
);

  localparam logic [3:0] STAB_MAX    = 4'(STABLE_CYCLES);
  localparam logic [9:0] TIMEOUT_MAX = 10'(TIMEOUT_CYCLES);

  localparam logic [3:0] CODE_ILLEGAL = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  typedef enum logic {
    WAIT_T = 1'b0,
    WAIT_O = 1'b1
  } state_t;

  state_t     state_q,     state_d;

  logic [7:0] sync1_q;
  logic [7:0] s_q;
  logic [7:0] sPrev_q;

  logic [3:0] stabCnt_q,   stabCnt_d;
  logic       captured_q,  captured_d;
  logic [9:0] toCnt_q,     toCnt_d;

  logic [3:0] tensHold_q,  tensHold_d;
  logic [3:0] onesHold_q,  onesHold_d;

  logic [3:0] tensOut_q,   tensOut_d;
  logic [3:0] onesOut_q,   onesOut_d;
  logic       valid_q,     valid_d;
  logic       update_q,    update_d;
  logic       invalidErr_q, invalidErr_d;
  logic       stalled_q,   stalled_d;

  logic       phaseStart;
  logic       capture;
  logic       captureTens;
  logic [3:0] captureCode;
  logic       timeoutHit;
  logic       publish;

  // Maps a gfedcba pattern back to the digit the encoder drove. The all-off
  // pattern is a legal blank; anything not in the table is flagged illegal.
  function automatic logic [3:0] decodeSeg(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      7'b0111111: code = 4'h0;
      7'b0000110: code = 4'h1;
      7'b1011011: code = 4'h2;
      7'b1001111: code = 4'h3;
      7'b1100110: code = 4'h4;
      7'b1101101: code = 4'h5;
      7'b1111101: code = 4'h6;
      7'b0000111: code = 4'h7;
      7'b1111111: code = 4'h8;
      7'b1101111: code = 4'h9;
      7'b0000000: code = CODE_BLANK;
      default:    code = CODE_ILLEGAL;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser for the asynchronous display bus, followed by a
  // one-cycle delayed copy so that select edges and segment changes can be
  // detected by comparing neighbouring samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      s_q     <= 8'h00;
      sPrev_q <= 8'h00;
    end else begin
      sync1_q <= bus.seg_in;
      s_q     <= sync1_q;
      sPrev_q <= s_q;
    end
  end

  // Event detection. stabCnt_q counts how many identical samples the value
  // held in sPrev_q has had, so the capture decodes sPrev_q. That lets the
  // last sample of a phase still be captured on the cycle the select flips,
  // which keeps two-cycle phases decodable when STABLE_CYCLES is 2.
  always_comb begin
    phaseStart  = s_q[7] ^ sPrev_q[7];
    capture     = (stabCnt_q == STAB_MAX) && !captured_q;
    captureTens = sPrev_q[7];
    captureCode = decodeSeg(sPrev_q[6:0]);
    timeoutHit  = (toCnt_q == TIMEOUT_MAX) && !phaseStart;
  end

  // Stability counter, per-phase capture flag, timeout counter and stall
  // flag. A select edge restarts everything for the new phase and always
  // wins over a timeout detected on the same cycle.
  always_comb begin
    stabCnt_d  = stabCnt_q;
    captured_d = captured_q;
    toCnt_d    = toCnt_q;
    stalled_d  = stalled_q;

    if (phaseStart) begin
      stabCnt_d = 4'd1;
    end else if (s_q[6:0] == sPrev_q[6:0]) begin
      if (stabCnt_q != STAB_MAX) begin
        stabCnt_d = stabCnt_q + 4'd1;
      end
    end else begin
      stabCnt_d = 4'd1;
    end

    if (capture) begin
      captured_d = 1'b1;
    end
    if (phaseStart || timeoutHit) begin
      captured_d = 1'b0;
    end

    if (phaseStart) begin
      toCnt_d = 10'd0;
    end else if (toCnt_q != TIMEOUT_MAX) begin
      toCnt_d = toCnt_q + 10'd1;
    end

    if (phaseStart) begin
      stalled_d = 1'b0;
    end else if (timeoutHit) begin
      stalled_d = 1'b1;
    end
  end

  // Pairing FSM and publish logic. A tens capture arms the FSM; the ones
  // capture that follows publishes the pair, forwarding the ones code being
  // captured on this very cycle. A second tens capture while armed simply
  // replaces the held tens value. A timeout discards any pending pair and
  // suppresses a capture landing on the same cycle.
  always_comb begin
    state_d      = state_q;
    tensHold_d   = tensHold_q;
    onesHold_d   = onesHold_q;
    publish      = 1'b0;
    tensOut_d    = tensOut_q;
    onesOut_d    = onesOut_q;
    valid_d      = valid_q;
    update_d     = 1'b0;
    invalidErr_d = 1'b0;

    if (timeoutHit) begin
      state_d = WAIT_T;
      valid_d = 1'b0;
    end else if (capture) begin
      if (captureTens) begin
        tensHold_d = captureCode;
      end else begin
        onesHold_d = captureCode;
      end

      case (state_q)
        WAIT_T: begin
          if (captureTens) begin
            state_d = WAIT_O;
          end
        end
        WAIT_O: begin
          if (!captureTens) begin
            publish = 1'b1;
            state_d = WAIT_T;
          end
        end
        default: state_d = WAIT_T;
      endcase
    end

    if (publish) begin
      tensOut_d    = tensHold_q;
      onesOut_d    = captureCode;
      valid_d      = 1'b1;
      update_d     = 1'b1;
      invalidErr_d = (tensHold_q == CODE_ILLEGAL) || (captureCode == CODE_ILLEGAL);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_T;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, hold registers and published outputs. Reset discards any
  // partially captured pair along with the published one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stabCnt_q    <= 4'd0;
      captured_q   <= 1'b0;
      toCnt_q      <= 10'd0;
      tensHold_q   <= 4'd0;
      onesHold_q   <= 4'd0;
      tensOut_q    <= 4'd0;
      onesOut_q    <= 4'd0;
      valid_q      <= 1'b0;
      update_q     <= 1'b0;
      invalidErr_q <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      stabCnt_q    <= stabCnt_d;
      captured_q   <= captured_d;
      toCnt_q      <= toCnt_d;
      tensHold_q   <= tensHold_d;
      onesHold_q   <= onesHold_d;
      tensOut_q    <= tensOut_d;
      onesOut_q    <= onesOut_d;
      valid_q      <= valid_d;
      update_q     <= update_d;
      invalidErr_q <= invalidErr_d;
      stalled_q    <= stalled_d;
    end
  end

  assign bus.tens_out    = tensOut_q;
  assign bus.ones_out    = onesOut_q;
  assign bus.valid       = valid_q;
  assign bus.update      = update_q;
  assign bus.invalid_err = invalidErr_q;
  assign bus.stalled     = stalled_q;

endmodule
